// File: rtl/uart_dbg_pkg.sv
// rtl/uart_dbg_pkg.sv - shared encodings for the UART TX debug arbiter
package uart_dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_0    = 2'b01;
  localparam logic [1:0] GRANT_1    = 2'b10;

  // Debug dump length; longer packets are cut off.
  localparam int MAX_PKT_DEFAULT = 96;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - two-input round-robin selector
// i_last1 = 1 means requester 1 was served most recently, so requester 0 wins a tie.
module rr_pick
  import uart_dbg_pkg::*;
(
  input  logic       i_req0,
  input  logic       i_req1,
  input  logic       i_last1,
  output logic [1:0] o_pick
);

  always_comb begin
    o_pick = GRANT_NONE;
    if (i_req0 && i_req1) begin
      o_pick = i_last1 ? GRANT_0 : GRANT_1;
    end else if (i_req0) begin
      o_pick = GRANT_0;
    end else if (i_req1) begin
      o_pick = GRANT_1;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-level arbiter of two byte streams onto the UART TX FIFO
// Ownership lasts a whole packet; requests are only sampled while idle.
module uart_tx_arbiter
  import uart_dbg_pkg::*;
#(
  parameter int MAX_PKT = MAX_PKT_DEFAULT,
  parameter int CNT_W   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0,
  input  logic             req0_valid,
  input  logic [7:0]       req0_data,
  input  logic             req0_last,
  output logic             req0_ready,
  input  logic             req1,
  input  logic             req1_valid,
  input  logic [7:0]       req1_data,
  input  logic             req1_last,
  output logic             req1_ready,
  input  logic             fifo_full,
  output logic             fifo_wr,
  output logic [7:0]       fifo_wdata,
  output logic [1:0]       grant,
  output logic             busy,
  output logic [CNT_W-1:0] byte_count,
  output logic             pkt_ovf
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PKT);

  arb_state_t       r_state, w_state_next;
  logic             r_last1, w_last1_next;
  logic [CNT_W-1:0] r_count, w_count_next, w_count_inc;
  logic [1:0]       w_pick;
  logic             w_own0, w_own1, w_valid, w_last, w_accept, w_at_max, w_end;
  logic [7:0]       w_data;

  rr_pick u_rr_pick (
    .i_req0  (req0),
    .i_req1  (req1),
    .i_last1 (r_last1),
    .o_pick  (w_pick)
  );

  assign w_own0 = (r_state == ST_OWN0);
  assign w_own1 = (r_state == ST_OWN1);

  always_comb begin
    w_valid = 1'b0;
    w_last  = 1'b0;
    w_data  = 8'h00;
    if (w_own0) begin
      w_valid = req0_valid;
      w_last  = req0_last;
      w_data  = req0_data;
    end else if (w_own1) begin
      w_valid = req1_valid;
      w_last  = req1_last;
      w_data  = req1_data;
    end
  end

  assign req0_ready  = w_own0 && !fifo_full;
  assign req1_ready  = w_own1 && !fifo_full;
  assign w_accept    = w_valid && !fifo_full;
  assign w_count_inc = r_count + CNT_W'(1);
  assign w_at_max    = (w_count_inc == MAX_CNT);
  assign w_end       = w_accept && (w_last || w_at_max);

  assign fifo_wr    = w_accept;
  assign fifo_wdata = w_data;
  assign grant      = w_own0 ? GRANT_0 : (w_own1 ? GRANT_1 : GRANT_NONE);
  assign busy       = w_own0 || w_own1;
  // Count includes the byte being accepted this cycle.
  assign byte_count = w_accept ? w_count_inc : r_count;
  assign pkt_ovf    = w_accept && !w_last && w_at_max;

  always_comb begin
    w_state_next = r_state;
    w_last1_next = r_last1;
    w_count_next = r_count;
    case (r_state)
      ST_IDLE: begin
        w_count_next = '0;
        if (w_pick == GRANT_0) begin
          w_state_next = ST_OWN0;
        end else if (w_pick == GRANT_1) begin
          w_state_next = ST_OWN1;
        end
      end
      ST_OWN0, ST_OWN1: begin
        if (w_end) begin
          w_state_next = ST_IDLE;
          w_count_next = '0;
          w_last1_next = w_own1;
        end else if (w_accept) begin
          w_count_next = w_count_inc;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_count_next = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_last1 <= 1'b1;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_last1 <= w_last1_next;
      r_count <= w_count_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic       req0, req0_valid, req0_last, req0_ready;
  logic [7:0] req0_data;
  logic       req1, req1_valid, req1_last, req1_ready;
  logic [7:0] req1_data;
  logic       fifo_full, fifo_wr;
  logic [7:0] fifo_wdata;
  logic [1:0] grant;
  logic       busy, pkt_ovf;
  logic [7:0] byte_count;

  int n_tests = 0;
  int n_fail  = 0;
  int n_wr, n_ovf, ovf_at, ovf_cnt;

  always #5 clock = ~clock;

  uart_tx_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .req0       (req0),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_last  (req0_last),
    .req0_ready (req0_ready),
    .req1       (req1),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_last  (req1_last),
    .req1_ready (req1_ready),
    .fifo_full  (fifo_full),
    .fifo_wr    (fifo_wr),
    .fifo_wdata (fifo_wdata),
    .grant      (grant),
    .busy       (busy),
    .byte_count (byte_count),
    .pkt_ovf    (pkt_ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 0; req0_valid = 0; req0_data = 8'h00; req0_last = 0;
    req1 = 0; req1_valid = 0; req1_data = 8'h00; req1_last = 0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_grant"}, 32'(grant), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_count"}, 32'(byte_count), 32'h0);
    check({tag, "_wr"}, 32'(fifo_wr), 32'h0);
  endtask

  initial begin
    reset = 1; fifo_full = 0;
    idle_inputs();
    req0 = 1; req0_valid = 1; req0_data = 8'h5A;
    #1;
    check_idle("rst");
    check("rst_ovf", 32'(pkt_ovf), 32'h0);
    check("rst_rdy0", 32'(req0_ready), 32'h0);
    check("rst_rdy1", 32'(req1_ready), 32'h0);
    check("rst_wdata", 32'(fifo_wdata), 32'h0);
    cyc();
    reset = 0;
    idle_inputs();
    cyc();

    // single 3-byte packet from requester 0
    req0 = 1; req0_valid = 1; req0_data = 8'hA1;
    #1;
    check("p0_idle_grant", 32'(grant), 32'h0);
    cyc();
    req0 = 0;
    check("p0_grant", 32'(grant), 32'h1);
    check("p0_busy", 32'(busy), 32'h1);
    check("p0_wr1", 32'(fifo_wr), 32'h1);
    check("p0_d1", 32'(fifo_wdata), 32'hA1);
    check("p0_c1", 32'(byte_count), 32'h1);
    check("p0_rdy1", 32'(req1_ready), 32'h0);
    cyc();
    req0_data = 8'hA2; #1;
    check("p0_d2", 32'(fifo_wdata), 32'hA2);
    check("p0_c2", 32'(byte_count), 32'h2);
    cyc();
    req0_data = 8'hA3; req0_last = 1; #1;
    check("p0_d3", 32'(fifo_wdata), 32'hA3);
    check("p0_c3", 32'(byte_count), 32'h3);
    check("p0_wr3", 32'(fifo_wr), 32'h1);
    cyc();
    idle_inputs(); #1;
    check_idle("p0_end");

    // tie after reset: req0, idle gap, req1, idle gap, req0
    reset = 1; #1; reset = 0;
    cyc();
    req0 = 1; req0_valid = 1; req0_data = 8'h01; req0_last = 1;
    req1 = 1; req1_valid = 1; req1_data = 8'h81; req1_last = 1;
    #1;
    check("tie_a_grant", 32'(grant), 32'h0);
    cyc();
    check("tie_b_grant", 32'(grant), 32'h1);
    check("tie_b_data", 32'(fifo_wdata), 32'h01);
    check("tie_b_rdy1", 32'(req1_ready), 32'h0);
    cyc();
    check("tie_c_grant", 32'(grant), 32'h0);
    check("tie_c_wr", 32'(fifo_wr), 32'h0);
    cyc();
    check("tie_d_grant", 32'(grant), 32'h2);
    check("tie_d_data", 32'(fifo_wdata), 32'h81);
    check("tie_d_rdy0", 32'(req0_ready), 32'h0);
    cyc();
    check("tie_e_grant", 32'(grant), 32'h0);
    cyc();
    check("tie_f_grant", 32'(grant), 32'h1);
    cyc();
    idle_inputs(); #1;
    check_idle("tie_end");

    // FIFO backpressure inside an OWN1 packet
    req1 = 1; req1_valid = 1; req1_data = 8'h10;
    cyc();
    check("bp_grant", 32'(grant), 32'h2);
    check("bp_d0", 32'(fifo_wdata), 32'h10);
    check("bp_c0", 32'(byte_count), 32'h1);
    cyc();
    req1 = 0; req1_data = 8'h11; req1_last = 1; fifo_full = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_stall_rdy", 32'(req1_ready), 32'h0);
      check("bp_stall_wr", 32'(fifo_wr), 32'h0);
      check("bp_stall_cnt", 32'(byte_count), 32'h1);
      cyc();
    end
    fifo_full = 0; #1;
    check("bp_wr", 32'(fifo_wr), 32'h1);
    check("bp_d1", 32'(fifo_wdata), 32'h11);
    check("bp_rdy", 32'(req1_ready), 32'h1);
    check("bp_c1", 32'(byte_count), 32'h2);
    cyc();
    idle_inputs(); #1;
    check_idle("bp_end");

    // req1 arrives mid OWN0 packet; req0 also drops valid and req between bytes
    req0 = 1; req0_valid = 1; req0_data = 8'hB0;
    cyc();
    req1 = 1; req1_valid = 1; req1_data = 8'hC0; req1_last = 1; #1;
    check("mid_d0", 32'(fifo_wdata), 32'hB0);
    check("mid_rdy1", 32'(req1_ready), 32'h0);
    cyc();
    req0 = 0; req0_valid = 0; #1;
    check("mid_gap_wr", 32'(fifo_wr), 32'h0);
    check("mid_gap_grant", 32'(grant), 32'h1);
    check("mid_gap_cnt", 32'(byte_count), 32'h1);
    check("mid_gap_rdy1", 32'(req1_ready), 32'h0);
    cyc();
    req0_valid = 1; req0_data = 8'hB1; req0_last = 1; #1;
    check("mid_d1", 32'(fifo_wdata), 32'hB1);
    check("mid_c1", 32'(byte_count), 32'h2);
    cyc();
    req0_valid = 0; req0_last = 0; #1;
    check("mid_idle_grant", 32'(grant), 32'h0);
    check("mid_idle_rdy1", 32'(req1_ready), 32'h0);
    cyc();
    check("mid_own1_grant", 32'(grant), 32'h2);
    check("mid_own1_data", 32'(fifo_wdata), 32'hC0);
    cyc();
    idle_inputs();

    // 100-byte stream without last is cut at 96; pending req1 goes next
    req0 = 1; req0_valid = 1;
    req1 = 1; req1_valid = 1; req1_data = 8'hD1; req1_last = 1;
    n_wr = 0; n_ovf = 0; ovf_at = 0; ovf_cnt = 0;
    for (int i = 0; i < 120 && n_ovf == 0; i++) begin
      req0_data = 8'(i); #1;
      if (fifo_wr && grant == 2'b01) n_wr++;
      if (pkt_ovf) begin
        n_ovf++;
        ovf_at = n_wr;
        ovf_cnt = 32'(byte_count);
      end
      cyc();
    end
    check("ovf_pulses", 32'(n_ovf), 32'd1);
    check("ovf_writes", 32'(n_wr), 32'd96);
    check("ovf_at_write", 32'(ovf_at), 32'd96);
    check("ovf_count", 32'(ovf_cnt), 32'd96);
    #1;
    check("ovf_after_pulse", 32'(pkt_ovf), 32'h0);
    check_idle("ovf_idle");
    cyc();
    check("ovf_next_grant", 32'(grant), 32'h2);
    check("ovf_next_data", 32'(fifo_wdata), 32'hD1);
    cyc();
    idle_inputs();
    cyc();

    // reset mid OWN1 packet, then tie resolves to req0
    req1 = 1; req1_valid = 1; req1_data = 8'hE0;
    cyc();
    check("rm_grant", 32'(grant), 32'h2);
    cyc();
    req1_data = 8'hE1; #1;
    check("rm_c1", 32'(byte_count), 32'h2);
    cyc();
    req1_data = 8'hE2; #1;
    check("rm_wr_before", 32'(fifo_wr), 32'h1);
    reset = 1; #1;
    check_idle("rm_rst");
    check("rm_rdy1", 32'(req1_ready), 32'h0);
    check("rm_wdata", 32'(fifo_wdata), 32'h0);
    req0 = 1; req0_valid = 1; req0_data = 8'hF0; req0_last = 1;
    cyc();
    check("rm_held_wr", 32'(fifo_wr), 32'h0);
    reset = 0; #1;
    check("rm_rel_grant", 32'(grant), 32'h0);
    cyc();
    check("rm_first_grant", 32'(grant), 32'h1);
    check("rm_first_data", 32'(fifo_wdata), 32'hF0);
    cyc();
    idle_inputs();
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter MAX_PKT, default 96, maximum bytes per granted packet before forced termination.
REQ-002 Parameter CNT_W, default 8, width of byte_count.
REQ-003 clock  input  1  rising-edge clock.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 req0  input  1  requester 0 (pipeline debug dump) wants the UART TX path.
REQ-006 req0_valid  input  1  req0_data holds a byte.
REQ-007 req0_data  input  8  byte from requester 0.
REQ-008 req0_last  input  1  current req0 byte ends the packet.
REQ-009 req0_ready  output  1  requester 0 byte accepted this cycle when valid.
REQ-010 req1, req1_valid, req1_data, req1_last, req1_ready: same directions, widths and meanings for requester 1 (command ack/echo).
REQ-011 fifo_full  input  1  UART TX FIFO cannot accept a write.
REQ-012 fifo_wr  output  1  write strobe into UART TX FIFO.
REQ-013 fifo_wdata  output  8  byte written to the FIFO.
REQ-014 grant  output  2  one-hot owner: 01 = req0, 10 = req1, 00 = none.
REQ-015 busy  output  1  a packet is in progress.
REQ-016 byte_count  output  CNT_W  bytes accepted in the current packet.
REQ-017 pkt_ovf  output  1  one-cycle pulse on forced termination at MAX_PKT.

Function
REQ-018 FSM states are IDLE, OWN0 and OWN1; grant = 00/01/10 respectively; busy = 1 in OWN0 and OWN1.
REQ-019 IDLE: with req0 only asserted -> OWN0 next cycle; with req1 only -> OWN1; with neither -> stay in IDLE.
REQ-020 IDLE with req0 and req1 both asserted: grant the requester not served most recently (round-robin pointer).
REQ-021 Round-robin pointer updates on every packet end, normal or forced, to the requester just served.
REQ-022 reqN_ready = (state == OWNN) && !fifo_full; the non-owner's ready is 0.
REQ-023 Accept = owner valid && ready.
REQ-024 fifo_wr = accept, combinational, same cycle.
REQ-025 fifo_wdata = owner data, combinational; 0 in IDLE.
REQ-026 fifo_full = 1: no write; no byte lost; the owner holds its byte.
REQ-027 byte_count increments by 1 per accept; it returns to 0 on entry to IDLE.
REQ-028 Accept with last = 1: state -> IDLE next cycle. The arbiter spends at least one IDLE cycle between packets.
REQ-029 Accept making byte_count == MAX_PKT while last = 0: state -> IDLE, pkt_ovf = 1 for one cycle, pointer rotates.
REQ-030 An owner that deasserts req mid-packet keeps the grant until last or MAX_PKT; reqN is sampled only in IDLE.
REQ-031 The owner's valid may drop between bytes; the FSM holds its state and the count is unchanged.
REQ-032 A non-owner's req, valid and data are ignored until IDLE.

Reset
REQ-033 On reset assertion, immediately:
- state = IDLE, grant = 00, busy = 0, byte_count = 0, pkt_ovf = 0
- fifo_wr = 0, req0_ready = 0, req1_ready = 0, fifo_wdata = 0
- pointer = "last served req1", so req0 wins the first tie.
REQ-034 Reset mid-packet abandons the packet with no further FIFO writes. The first grant after release follows REQ-019/020.

Structure
REQ-035 Shared package uart_dbg_pkg holds:
- state encoding (IDLE = 0, OWN0 = 1, OWN1 = 2)
- grant codes
- MAX_PKT default 96 (debug dump length).
REQ-036 One sub-module rr_pick: combinational two-input round-robin selector (req0, req1, pointer -> one-hot choice). All state lives in uart_tx_arbiter.

Verification
REQ-037 Release reset; req0 = 1 with 3-byte packet 0xA1, 0xA2, 0xA3 (last on 0xA3), fifo_full = 0 -> grant = 01 next cycle; fifo_wr on 3 consecutive cycles with those bytes; byte_count 1, 2, 3; IDLE after.
REQ-038 req0 and req1 asserted together from IDLE after reset -> req0 served first; req1 granted after one IDLE cycle; a further tie grants req0.
REQ-039 During an OWN1 packet 0x10, 0x11, hold fifo_full = 1 for 4 cycles before 0x11 -> req1_ready = 0 and fifo_wr = 0 for those 4 cycles; 0x11 written in the first cycle after fifo_full = 0.
REQ-040 req0 streams 100 bytes, last never set, MAX_PKT = 96 -> exactly 96 writes; pkt_ovf pulses once; a pending req1 is granted next.
REQ-041 Assert reset after 2 of 5 bytes of an OWN1 packet -> fifo_wr = 0, grant = 00, byte_count = 0 immediately. After release with both requesting, req0 is granted first.
REQ-042 req1 asserts mid OWN0 packet -> no req1_ready and no req1 data written until req0's last byte is accepted.
